pc_sequencer: RTL and testbench

Multicycle instruction sequencer for the i281 core. It holds the program counter and the flag register, and steps each instruction through a four-phase FSM. It decides the branch (`c2`) for the combinational `pc_update` stage, then commits that stage's `next_pc` back into the PC. It drives `current_pc`, `offset` and `c2` into `pc_update` and consumes `next_pc` from it.

---
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Multicycle instruction sequencer for the i281 core. Holds the program
//   counter and the {C,O,N,Z} flag register and walks each instruction through
//   FETCH -> DECODE -> EXECUTE -> UPDATE. It resolves the branch select (c2)
//   for the external combinational pc_update stage and commits that stage's
//   next_pc on the UPDATE edge. No PC arithmetic is performed here.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_run         allow a new instruction to start (sampled in FETCH only)
//   i_is_branch   decoder: branch/jump instruction (sampled in DECODE)
//   i_br_cond     decoder: branch condition code (sampled in DECODE)
//   i_br_offset   decoder: signed branch offset (sampled in DECODE)
//   i_flag_we     ALU instruction writes flags (sampled in EXECUTE)
//   i_alu_flags   {C,O,N,Z} from the ALU (sampled in EXECUTE)
//   i_next_pc     next PC from pc_update
//   o_current_pc  registered PC
//   o_offset      latched branch offset, to pc_update
//   o_c2          branch-taken select, to pc_update (UPDATE phase only)
//   o_flags       registered {C,O,N,Z}
//   o_phase       00 FETCH, 01 DECODE, 10 EXECUTE, 11 UPDATE
//   o_retire      high for the single UPDATE cycle of each instruction
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter int unsigned PC_W = 6
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_run,
   input  logic            i_is_branch,
   input  logic [2:0]      i_br_cond,
   input  logic [PC_W-1:0] i_br_offset,
   input  logic            i_flag_we,
   input  logic [3:0]      i_alu_flags,
   input  logic [PC_W-1:0] i_next_pc,
   output logic [PC_W-1:0] o_current_pc,
   output logic [PC_W-1:0] o_offset,
   output logic            o_c2,
   output logic [3:0]      o_flags,
   output logic [1:0]      o_phase,
   output logic            o_retire
);

   typedef enum logic [1:0] {
      ST_FETCH   = 2'b00,
      ST_DECODE  = 2'b01,
      ST_EXECUTE = 2'b10,
      ST_UPDATE  = 2'b11
   } state_t;

   typedef enum logic [2:0] {
      CC_NONE = 3'b000,
      CC_JUMP = 3'b001,
      CC_BRZ  = 3'b010,
      CC_BRNZ = 3'b011,
      CC_BRG  = 3'b100,
      CC_BRGE = 3'b101
   } cond_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_offset;
   logic [2:0]      r_cond;
   logic [3:0]      r_flags;
   logic            w_cond_true;
   logic            w_flag_c;
   logic            w_flag_o;
   logic            w_flag_n;
   logic            w_flag_z;

   assign {w_flag_c, w_flag_o, w_flag_n, w_flag_z} = r_flags;

   // State register plus the per-phase data captures.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= ST_FETCH;
         r_pc     <= '0;
         r_offset <= '0;
         r_cond   <= '0;
         r_flags  <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_DECODE: begin
               r_offset <= i_br_offset;
               // Non-branch instructions carry condition "none" so c2 stays 0.
               r_cond   <= i_is_branch ? i_br_cond : 3'b000;
            end
            ST_EXECUTE: begin
               if (i_flag_we) begin
                  r_flags <= i_alu_flags;
               end
            end
            ST_UPDATE: begin
               r_pc <= i_next_pc;
            end
            default: ;
         endcase
      end
   end

   // Next-state, branch resolution and phase outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_cond_true = 1'b0;
      o_c2        = 1'b0;
      o_retire    = 1'b0;

      case (r_state)
         ST_FETCH:   w_state_nxt = i_run ? ST_DECODE : ST_FETCH;
         ST_DECODE:  w_state_nxt = ST_EXECUTE;
         ST_EXECUTE: w_state_nxt = ST_UPDATE;
         ST_UPDATE:  w_state_nxt = ST_FETCH;
         default:    w_state_nxt = ST_FETCH;
      endcase

      case (r_cond)
         CC_JUMP: w_cond_true = 1'b1;
         CC_BRZ:  w_cond_true = w_flag_z;
         CC_BRNZ: w_cond_true = ~w_flag_z;
         CC_BRG:  w_cond_true = ~w_flag_z & (w_flag_n == w_flag_o);
         CC_BRGE: w_cond_true = (w_flag_n == w_flag_o);
         default: w_cond_true = 1'b0;
      endcase

      if (r_state == ST_UPDATE) begin
         o_c2     = w_cond_true;
         o_retire = 1'b1;
      end
   end

   assign o_current_pc = r_pc;
   assign o_offset     = r_offset;
   assign o_flags      = r_flags;
   assign o_phase      = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed bench for pc_sequencer with a behavioural pc_update stage closing
//   the loop. Expected PCs are queued when an instruction is decoded and
//   compared once it has retired.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

   localparam int unsigned PC_W = 6;

   logic            clk;
   logic            rst_n;
   logic            run;
   logic            is_branch;
   logic [2:0]      br_cond;
   logic [PC_W-1:0] br_offset;
   logic            flag_we;
   logic [3:0]      alu_flags;
   logic [PC_W-1:0] next_pc;
   logic [PC_W-1:0] current_pc;
   logic [PC_W-1:0] offset;
   logic            c2;
   logic [3:0]      flags;
   logic [1:0]      phase;
   logic            retire;

   int checks   = 0;
   int failures = 0;

   logic [PC_W-1:0] sb_q[$];
   logic [PC_W-1:0] e_pc;
   logic [3:0]      e_flags;

   pc_sequencer #(.PC_W(PC_W)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_run        (run),
      .i_is_branch  (is_branch),
      .i_br_cond    (br_cond),
      .i_br_offset  (br_offset),
      .i_flag_we    (flag_we),
      .i_alu_flags  (alu_flags),
      .i_next_pc    (next_pc),
      .o_current_pc (current_pc),
      .o_offset     (offset),
      .o_c2         (c2),
      .o_flags      (flags),
      .o_phase      (phase),
      .o_retire     (retire)
   );

   // Behavioural pc_update stage.
   assign next_pc = c2 ? (current_pc + 6'd1 + offset) : (current_pc + 6'd1);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One instruction from FETCH back to FETCH. Decoder/flag inputs are driven
   // with junk outside their sampling phase to show they are ignored.
   task automatic do_instr(input logic br, input logic [2:0] cond,
                           input logic [5:0] off, input logic fwe,
                           input logic [3:0] af, input logic exp_c2,
                           input logic drop_run);
      logic [5:0] exp_pc;
      logic [5:0] got;
      chk("fetch_phase", {6'd0, phase}, 8'h00);
      run = 1'b1;
      step();
      chk("dec_phase", {6'd0, phase}, 8'h01);
      chk("dec_c2", {7'd0, c2}, 8'h00);
      chk("dec_retire", {7'd0, retire}, 8'h00);
      is_branch = br;
      br_cond   = cond;
      br_offset = off;
      flag_we   = 1'b1;
      alu_flags = ~af;
      exp_pc    = e_pc + 6'd1 + (exp_c2 ? off : 6'd0);
      sb_q.push_back(exp_pc);
      step();
      chk("exe_phase", {6'd0, phase}, 8'h02);
      chk("exe_offset", {2'd0, offset}, {2'd0, off});
      chk("exe_flags_hold", {4'd0, flags}, {4'd0, e_flags});
      chk("exe_c2", {7'd0, c2}, 8'h00);
      flag_we   = fwe;
      alu_flags = af;
      is_branch = ~br;
      br_cond   = ~cond;
      br_offset = ~off;
      if (drop_run) run = 1'b0;
      if (fwe) e_flags = af;
      step();
      chk("upd_phase", {6'd0, phase}, 8'h03);
      chk("upd_retire", {7'd0, retire}, 8'h01);
      chk("upd_c2", {7'd0, c2}, {7'd0, exp_c2});
      chk("upd_flags", {4'd0, flags}, {4'd0, e_flags});
      chk("upd_offset", {2'd0, offset}, {2'd0, off});
      flag_we   = 1'b1;
      alu_flags = ~af;
      step();
      chk("ret_phase", {6'd0, phase}, 8'h00);
      chk("ret_retire", {7'd0, retire}, 8'h00);
      chk("ret_flags", {4'd0, flags}, {4'd0, e_flags});
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $error("FAIL sb_empty observed=0 expected=1");
      end else begin
         got = sb_q.pop_front();
         checks--;
         chk("ret_pc", {2'd0, current_pc}, {2'd0, got});
      end
      e_pc      = exp_pc;
      flag_we   = 1'b0;
      alu_flags = 4'h0;
      is_branch = 1'b0;
      br_cond   = 3'b000;
      br_offset = '0;
   endtask

   initial begin
      rst_n     = 1'b0;
      run       = 1'b0;
      is_branch = 1'b0;
      br_cond   = 3'b000;
      br_offset = '0;
      flag_we   = 1'b0;
      alu_flags = 4'h0;
      e_pc      = '0;
      e_flags   = 4'h0;

      repeat (2) step();
      chk("rst_phase", {6'd0, phase}, 8'h00);
      chk("rst_pc", {2'd0, current_pc}, 8'h00);
      chk("rst_offset", {2'd0, offset}, 8'h00);
      chk("rst_flags", {4'd0, flags}, 8'h00);
      chk("rst_c2", {7'd0, c2}, 8'h00);
      chk("rst_retire", {7'd0, retire}, 8'h00);
      rst_n = 1'b1;

      // Straight-line: 0 -> 1 -> 2 -> 3.
      do_instr(1'b0, 3'b000, 6'h00, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("seq_pc1", {2'd0, current_pc}, 8'h01);
      do_instr(1'b0, 3'b000, 6'h00, 1'b0, 4'h0, 1'b0, 1'b0);
      do_instr(1'b0, 3'b000, 6'h00, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("seq_pc3", {2'd0, current_pc}, 8'h03);

      // JUMP tests.
      do_instr(1'b1, 3'b001, 6'h0C, 1'b0, 4'h0, 1'b1, 1'b0);
      chk("jmp_to_10", {2'd0, current_pc}, 8'h10);
      do_instr(1'b1, 3'b001, 6'h34, 1'b0, 4'h0, 1'b1, 1'b0);
      chk("jmp_neg12", {2'd0, current_pc}, 8'h05);
      do_instr(1'b1, 3'b001, 6'h0A, 1'b0, 4'h0, 1'b1, 1'b0);
      do_instr(1'b0, 3'b001, 6'h34, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("nobr_jmp", {2'd0, current_pc}, 8'h11);

      // BRZ taken / not taken from PC 8.
      do_instr(1'b1, 3'b001, 6'h35, 1'b0, 4'h0, 1'b1, 1'b0);
      do_instr(1'b0, 3'b000, 6'h00, 1'b1, 4'b0001, 1'b0, 1'b0);
      chk("pc_8a", {2'd0, current_pc}, 8'h08);
      do_instr(1'b1, 3'b010, 6'h03, 1'b0, 4'h0, 1'b1, 1'b0);
      chk("brz_taken", {2'd0, current_pc}, 8'h0C);
      do_instr(1'b0, 3'b000, 6'h00, 1'b1, 4'b0000, 1'b0, 1'b0);
      do_instr(1'b1, 3'b001, 6'h39, 1'b0, 4'h0, 1'b1, 1'b0);
      do_instr(1'b0, 3'b000, 6'h00, 1'b1, 4'b0000, 1'b0, 1'b0);
      chk("pc_8b", {2'd0, current_pc}, 8'h08);
      do_instr(1'b1, 3'b010, 6'h03, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("brz_not", {2'd0, current_pc}, 8'h09);
      do_instr(1'b1, 3'b011, 6'h02, 1'b0, 4'h0, 1'b1, 1'b0);
      chk("brnz_taken", {2'd0, current_pc}, 8'h0C);

      // BRG / BRGE sweep.
      do_instr(1'b0, 3'b000, 6'h00, 1'b1, 4'b0110, 1'b0, 1'b0);
      do_instr(1'b1, 3'b100, 6'h01, 1'b0, 4'h0, 1'b1, 1'b0);
      do_instr(1'b1, 3'b101, 6'h01, 1'b0, 4'h0, 1'b1, 1'b0);
      do_instr(1'b0, 3'b000, 6'h00, 1'b1, 4'b0010, 1'b0, 1'b0);
      do_instr(1'b1, 3'b100, 6'h01, 1'b0, 4'h0, 1'b0, 1'b0);
      do_instr(1'b1, 3'b101, 6'h01, 1'b0, 4'h0, 1'b0, 1'b0);
      do_instr(1'b0, 3'b000, 6'h00, 1'b1, 4'b0001, 1'b0, 1'b0);
      do_instr(1'b1, 3'b100, 6'h01, 1'b0, 4'h0, 1'b0, 1'b0);
      do_instr(1'b1, 3'b101, 6'h01, 1'b0, 4'h0, 1'b1, 1'b0);
      chk("sweep_pc", {2'd0, current_pc}, 8'h18);
      do_instr(1'b1, 3'b110, 6'h01, 1'b0, 4'h0, 1'b0, 1'b0);
      do_instr(1'b0, 3'b000, 6'h00, 1'b1, 4'b1111, 1'b0, 1'b0);
      do_instr(1'b1, 3'b111, 6'h01, 1'b0, 4'h0, 1'b0, 1'b0);
      do_instr(1'b1, 3'b110, 6'h01, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("rsvd_pc", {2'd0, current_pc}, 8'h1C);

      // Wrap-around through pc_update.
      do_instr(1'b1, 3'b001, 6'h21, 1'b0, 4'h0, 1'b1, 1'b0);
      chk("pc_62", {2'd0, current_pc}, 8'h3E);
      do_instr(1'b0, 3'b000, 6'h00, 1'b0, 4'h0, 1'b0, 1'b0);
      do_instr(1'b0, 3'b000, 6'h00, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("wrap_0", {2'd0, current_pc}, 8'h00);
      do_instr(1'b1, 3'b001, 6'h3C, 1'b0, 4'h0, 1'b1, 1'b0);
      chk("wrap_neg", {2'd0, current_pc}, 8'h3D);

      // run=0 in FETCH holds.
      run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_phase", {6'd0, phase}, 8'h00);
         chk("hold_pc", {2'd0, current_pc}, 8'h3D);
      end

      // run dropped in EXECUTE: completes, then parks in FETCH.
      do_instr(1'b0, 3'b000, 6'h00, 1'b0, 4'h0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stop_phase", {6'd0, phase}, 8'h00);
         chk("stop_pc", {2'd0, current_pc}, 8'h3E);
      end
      chk("pre_rst_flags", {4'd0, flags}, 8'h0F);

      // Asynchronous reset mid-EXECUTE.
      run = 1'b1;
      step();
      is_branch = 1'b1;
      br_cond   = 3'b001;
      br_offset = 6'h15;
      step();
      chk("ar_phase_exe", {6'd0, phase}, 8'h02);
      chk("ar_offset", {2'd0, offset}, 8'h15);
      flag_we   = 1'b1;
      alu_flags = 4'b0101;
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_phase", {6'd0, phase}, 8'h00);
      chk("ar_pc", {2'd0, current_pc}, 8'h00);
      chk("ar_offset0", {2'd0, offset}, 8'h00);
      chk("ar_flags", {4'd0, flags}, 8'h00);
      chk("ar_c2", {7'd0, c2}, 8'h00);
      chk("ar_retire", {7'd0, retire}, 8'h00);
      step();
      chk("ar_flags_held", {4'd0, flags}, 8'h00);
      chk("ar_phase_held", {6'd0, phase}, 8'h00);
      flag_we   = 1'b0;
      alu_flags = 4'h0;
      is_branch = 1'b0;
      br_cond   = 3'b000;
      br_offset = '0;
      rst_n     = 1'b1;
      e_pc      = '0;
      e_flags   = 4'h0;
      do_instr(1'b0, 3'b000, 6'h00, 1'b0, 4'h0, 1'b0, 1'b0);
      chk("post_rst_pc", {2'd0, current_pc}, 8'h01);
      chk("sb_drained", 8'(sb_q.size()), 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
